fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the single-cycle core.
- Owns the program counter and issues read requests to the instruction cache using a busywait handshake.
- Buffers fetched instructions, tagged with their PC, in a DEPTH-entry queue that feeds decode through a valid/ready handshake.
- Handles jump/branch redirects by flushing the queue and cancelling in-flight fetches. This decouples fetch stalls from data-cache stalls.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared state encoding and target arithmetic for the fetch unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic int unsigned instr_bytes(input int unsigned instr_w);
    return instr_w / 8;
  endfunction

  // Operates at 64 bits; callers truncate to ADDR_W, which yields the mod-2^ADDR_W result.
  function automatic logic [63:0] calc_target(input logic [63:0]  pc,
                                              input logic [63:0]  off_sext,
                                              input int unsigned  bytes);
    return pc + 64'(bytes) + (off_sext << 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : Synchronous FIFO with flush; flush beats push, wrap-bit pointers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int             PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_PTR_ONE = (PTR_W + 1)'(1);

  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = i_pop && !o_empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge CLK) begin
    if (RESET || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : PC owner, I-cache busywait requester and decode-side fetch queue.
//            Optional performance counters enabled by FETCH_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               INSTR_W  = 32,
  parameter int               OFFSET_W = 8,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic                IC_READ,
  output logic [ADDR_W-1:0]   IC_ADDR,
  input  logic                IC_BUSYWAIT,
  input  logic [INSTR_W-1:0]  IC_INSTR,
  output logic                INSTR_VALID,
  input  logic                INSTR_READY,
  output logic [INSTR_W-1:0]  INSTR,
  output logic [ADDR_W-1:0]   INSTR_PC,
  input  logic                REDIRECT,
  input  logic [OFFSET_W-1:0] REDIRECT_OFFSET
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]         PERF_MISS_CYCLES,
  output logic [15:0]         PERF_FLUSHES
`endif
);

  localparam int unsigned      INSTR_BYTES = instr_bytes(INSTR_W);
  localparam int               Q_W         = ADDR_W + INSTR_W;
  localparam int               CNT_W       = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] C_PC_STEP  = ADDR_W'(INSTR_BYTES);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_target;
  logic [ADDR_W-1:0] w_target_nxt;
  logic [ADDR_W-1:0] w_target;
  logic              w_complete;
  logic              w_pop;
  logic              w_push;
  logic              w_redirect;
  logic              w_room;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic [Q_W-1:0]    w_head;

  assign IC_READ     = !RESET && (r_state != HOLD);
  assign IC_ADDR     = r_fetch_pc;
  assign w_complete  = IC_READ && !IC_BUSYWAIT;
  assign w_pop       = INSTR_VALID && INSTR_READY;
  assign w_redirect  = w_pop && REDIRECT;
  assign w_push      = (r_state == FETCH) && w_complete;
  assign w_room      = (int'(w_count) + int'(w_push) - int'(w_pop)) < DEPTH;
  assign w_target    = ADDR_W'(calc_target(64'(INSTR_PC),
                                           64'($signed(REDIRECT_OFFSET)),
                                           INSTR_BYTES));

  assign INSTR_VALID = !w_empty;
  assign INSTR       = w_empty ? '0 : w_head[INSTR_W-1:0];
  assign INSTR_PC    = w_empty ? '0 : w_head[Q_W-1:INSTR_W];

  fetch_queue #(
    .WIDTH (Q_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_push      (w_push),
    .i_push_data ({r_fetch_pc, IC_INSTR}),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_target   <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_target_nxt   = r_target;
    case (r_state)
      FETCH: begin
        if (w_redirect) begin
          // An outstanding read cannot be aborted, so it must be drained first.
          if (w_complete) begin
            w_fetch_pc_nxt = w_target;
          end else begin
            w_target_nxt = w_target;
            w_state_nxt  = DRAIN;
          end
        end else if (w_complete) begin
          w_fetch_pc_nxt = r_fetch_pc + C_PC_STEP;
          if (!w_room) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_redirect) begin
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = FETCH;
        end else if (!w_full || w_pop) begin
          w_state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (w_complete) begin
          w_fetch_pc_nxt = r_target;
          w_state_nxt    = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_miss;
  logic [15:0] r_perf_flush;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_perf_miss  <= '0;
      r_perf_flush <= '0;
    end else begin
      if (IC_READ && IC_BUSYWAIT && (r_perf_miss != 16'hFFFF))
        r_perf_miss <= r_perf_miss + 16'd1;
      if (w_redirect && (r_perf_flush != 16'hFFFF))
        r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign PERF_MISS_CYCLES = r_perf_miss;
  assign PERF_FLUSHES     = r_perf_flush;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit (FETCH_PERF_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IC_READ;
  logic [31:0] IC_ADDR;
  logic        IC_BUSYWAIT = 1'b0;
  logic [31:0] IC_INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        REDIRECT = 1'b0;
  logic [7:0]  REDIRECT_OFFSET = 8'h00;
`ifdef FETCH_PERF_EN
  logic [15:0] PERF_MISS_CYCLES;
  logic [15:0] PERF_FLUSHES;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign IC_INSTR = ins(IC_ADDR);

  fetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .OFFSET_W (8),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .IC_READ         (IC_READ),
    .IC_ADDR         (IC_ADDR),
    .IC_BUSYWAIT     (IC_BUSYWAIT),
    .IC_INSTR        (IC_INSTR),
    .INSTR_VALID     (INSTR_VALID),
    .INSTR_READY     (INSTR_READY),
    .INSTR           (INSTR),
    .INSTR_PC        (INSTR_PC),
    .REDIRECT        (REDIRECT),
    .REDIRECT_OFFSET (REDIRECT_OFFSET)
`ifdef FETCH_PERF_EN
    ,
    .PERF_MISS_CYCLES(PERF_MISS_CYCLES),
    .PERF_FLUSHES    (PERF_FLUSHES)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Leaves the bench in the first cycle after reset deasserts.
  task automatic do_reset(input logic busy, input logic ready);
    RESET = 1'b1; REDIRECT = 1'b0; REDIRECT_OFFSET = 8'h00;
    IC_BUSYWAIT = busy; INSTR_READY = ready;
    tick(); tick();
    RESET = 1'b0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state and streaming fetch
    RESET = 1'b1; IC_BUSYWAIT = 1'b0; INSTR_READY = 1'b1;
    tick(); tick();
    check("rst_ic_read", IC_READ, 0);
    check("rst_valid", INSTR_VALID, 0);
    check("rst_ic_addr", IC_ADDR, 0);
    check("rst_instr", INSTR, 0);
    check("rst_instr_pc", INSTR_PC, 0);
    RESET = 1'b0;
    settle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seq_addr%0d", k), IC_ADDR, 64'(4 * k));
      check($sformatf("seq_read%0d", k), IC_READ, 1);
      if (k == 0) begin
        check("seq_valid0", INSTR_VALID, 0);
      end else begin
        check($sformatf("seq_valid%0d", k), INSTR_VALID, 1);
        check($sformatf("seq_pc%0d", k), INSTR_PC, 64'(4 * (k - 1)));
        check($sformatf("seq_instr%0d", k), INSTR, 64'(ins(32'(4 * (k - 1)))));
      end
      tick();
    end

    // Back-pressure fills the queue, then a single pop restarts fetch
    do_reset(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fill_addr%0d", k), IC_ADDR, 64'(4 * k));
      check($sformatf("fill_read%0d", k), IC_READ, 1);
      tick();
    end
    check("hold_read", IC_READ, 0);
    check("hold_addr", IC_ADDR, 32'h10);
    check("hold_head_pc", INSTR_PC, 0);
    tick();
    check("hold_read2", IC_READ, 0);
    INSTR_READY = 1'b1; settle();
    tick();
    INSTR_READY = 1'b0; settle();
    check("resume_read", IC_READ, 1);
    check("resume_addr", IC_ADDR, 32'h10);
    check("resume_head_pc", INSTR_PC, 32'h4);
    tick();
    check("rehold_read", IC_READ, 0);
    check("rehold_addr", IC_ADDR, 32'h14);

    // Redirect with a completion in the same cycle
    do_reset(1'b0, 1'b1);
    tick(); tick(); tick();
    check("rd_head_pc", INSTR_PC, 32'h8);
    REDIRECT = 1'b1; REDIRECT_OFFSET = 8'h03; settle();
    tick();
    REDIRECT = 1'b0; settle();
    check("rd_flush_valid", INSTR_VALID, 0);
    check("rd_tgt_addr", IC_ADDR, 32'h18);
    tick();
    check("rd_tgt_pc", INSTR_PC, 32'h18);
    check("rd_tgt_instr", INSTR, 64'(ins(32'h18)));
    tick();
    check("rd_next_pc", INSTR_PC, 32'h1C);

    // Redirect during a stalled read goes through DRAIN
    do_reset(1'b0, 1'b0);
    tick(); tick(); tick();
    check("dr_addr_c", IC_ADDR, 32'hC);
    IC_BUSYWAIT = 1'b1; INSTR_READY = 1'b1;
    REDIRECT = 1'b1; REDIRECT_OFFSET = 8'hFE; settle();
    check("dr_head_pc", INSTR_PC, 0);
    tick();
    REDIRECT = 1'b0; settle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("dr_hold_addr%0d", k), IC_ADDR, 32'hC);
      check($sformatf("dr_hold_read%0d", k), IC_READ, 1);
      check($sformatf("dr_hold_valid%0d", k), INSTR_VALID, 0);
      tick();
    end
    IC_BUSYWAIT = 1'b0; settle();
    check("dr_last_addr", IC_ADDR, 32'hC);
`ifdef FETCH_PERF_EN
    check("perf_miss", PERF_MISS_CYCLES, 5);
    check("perf_flush", PERF_FLUSHES, 1);
`endif
    tick();
    check("dr_tgt_addr", IC_ADDR, 32'hFFFF_FFFC);
    check("dr_discard_valid", INSTR_VALID, 0);
    tick();
    check("dr_tgt_valid", INSTR_VALID, 1);
    check("dr_tgt_pc", INSTR_PC, 32'hFFFF_FFFC);
    check("dr_wrap_addr", IC_ADDR, 0);

    // Target arithmetic wraps at 2^32
    do_reset(1'b0, 1'b1);
    tick();
    REDIRECT = 1'b1; REDIRECT_OFFSET = 8'hFD; settle();
    tick();
    REDIRECT = 1'b0; settle();
    check("wrap_setup_addr", IC_ADDR, 32'hFFFF_FFF8);
    tick();
    check("wrap_head_pc", INSTR_PC, 32'hFFFF_FFF8);
    REDIRECT = 1'b1; REDIRECT_OFFSET = 8'h01; settle();
    tick();
    REDIRECT = 1'b0; settle();
    check("wrap_tgt_addr", IC_ADDR, 0);
    check("wrap_flush_valid", INSTR_VALID, 0);
    tick();
    check("wrap_tgt_pc", INSTR_PC, 0);
    check("wrap_tgt_instr", INSTR, 64'(ins(32'h0)));

    // Reset in the middle of DRAIN
    do_reset(1'b0, 1'b1);
    tick();
    IC_BUSYWAIT = 1'b1; REDIRECT = 1'b1; REDIRECT_OFFSET = 8'h03; settle();
    tick();
    REDIRECT = 1'b0; settle();
    check("mid_drain_addr", IC_ADDR, 32'h4);
    check("mid_drain_read", IC_READ, 1);
    RESET = 1'b1; settle();
    check("rst_drain_read", IC_READ, 0);
    tick();
    RESET = 1'b0; IC_BUSYWAIT = 1'b0; settle();
    check("post_rst_valid", INSTR_VALID, 0);
    check("post_rst_read", IC_READ, 1);
    check("post_rst_addr", IC_ADDR, 0);
`ifdef FETCH_PERF_EN
    check("post_rst_miss", PERF_MISS_CYCLES, 0);
    check("post_rst_flush", PERF_FLUSHES, 0);
`endif
    tick();
    check("post_rst_head_valid", INSTR_VALID, 1);
    check("post_rst_head_pc", INSTR_PC, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
